flag_branch_unit: RTL
=====================

# flag_branch_unit

Downstream neighbour of the ALU in the WISC-F23 single-cycle datapath. Captures the ALU's N/Z/V flags into the architectural flag register under per-bit enables, qualified by instruction retirement. Evaluates the 3-bit branch condition of B/BR instructions against the registered flags and drives `taken` to the PC-select logic. Optionally keeps saturating branch statistics counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flag_in`  in  3  ALU flags {N,Z,V}; bit 2 = N, bit 1 = Z, bit 0 = V.
- `flag_en`  in  3  ALU per-bit update enables, same bit order as `flag_in`.
- `retire`  in  1  the current instruction completes this cycle; low during stall or HLT.
- `branch`  in  1  the current instruction is B or BR.
- `cond`  in  3  branch condition code from instruction bits [11:9].
- `flags_q`  out  3  registered {N,Z,V}.
- `taken`  out  1  branch taken this cycle; combinational.
- `br_cnt`  out  CNT_W  branches retired; statistics feature only.
- `tk_cnt`  out  CNT_W  branches taken; statistics feature only.

Clock and reset are one clock `clk` with a synchronous, active-low reset `rst_n`.

## Operation
- **Flag update.** On each edge with `rst_n` = 1 and `retire` = 1, for each bit i: `flags_q[i] <= flag_en[i] ? flag_in[i] : flags_q[i]`. When `retire` = 0, all flags hold.
- **Enable patterns.** ADD/SUB update all three flags (enable 111). XOR, RED, shifts and PADDSB update Z only (010). Memory, load/store and control instructions update none (000).
- **Flag validity.** `flag_in` bits whose enable is 0 may be X and must never propagate into `flags_q`.
- **Condition evaluation.** Conditions use `flags_q`, i.e. flags left by earlier instructions, never the same-cycle `flag_in`.
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OV: V=1
  - 111 UN: always
- **taken.** `taken = branch & retire & cond_met & rst_n`.
- **Branch flags.** A branch carries `flag_en` = 000, so branching never alters flags.

## Timing
- **Reset.** Edge with `rst_n` = 0 sets `flags_q` = 000, `br_cnt` = 0 and `tk_cnt` = 0. `taken` is 0 throughout reset.
- **Reset mid-operation.** Reset dominates `retire`; a pending flag write in the reset cycle is dropped.
- **Flag latency.** Flags written at edge k are visible to `flags_q` and to a branch evaluated in cycle k+1. There is zero-cycle combinational latency from `cond`/`branch` to `taken`.
- **Back-to-back.** In SUB then B EQ, the branch sees the SUB's Z.
- **Simultaneous events.** A non-retiring branch (stall) yields `taken` = 0 and does not count.

## Configuration
- **Macro:** `FLAG_BRANCH_STATS_EN`.
- **Defined.**
  - `br_cnt` increments on every retired branch.
  - `tk_cnt` increments on every cycle with `taken` = 1.
  - Both saturate at all-ones (no wrap).
  - Both increment in the same edge when applicable.
- **Undefined.** Counters are not instantiated; `br_cnt` and `tk_cnt` are tied to 0. Flag and branch behaviour is identical in both builds.

## Structure
- **Shared package `wisc_pkg`:**
  - localparams for condition codes (`COND_NE` … `COND_UN`);
  - flag bit indices (`FLAG_N` = 2, `FLAG_Z` = 1, `FLAG_V` = 0);
  - the `flags_t` 3-bit typedef.
- **Sub-module `branch_cond_eval`:** combinational, (`cond`, `flags`) → `cond_met`. It is reused by the BR target mux logic.
- **Top level:** the flag register and the optional counters live in the top module.

## Test plan
- **Reset and enables.** Reset, then retire with `flag_in`=111, `flag_en`=010 → `flags_q`=010. A further cycle with `retire`=0 and `flag_en`=111, `flag_in`=101 → `flags_q` stays 010.
- **Condition sweep.** Load `flags_q`=100 (N). Sweep `cond` 000–111 with `branch`=`retire`=1 → `taken` = 1,0,0,1,0,1,0,1.
- **Ordering.** SUB 5−5 (`flag_in`=010, en 111), then B EQ → `taken`=1 in the next cycle. B EQ in the same cycle as the SUB uses the prior flags (000) → `taken`=0.
- **Reset mid-operation.** Assert `rst_n`=0 in a cycle with `retire`=1, `flag_en`=111, `flag_in`=111 → `flags_q`=000 and `taken`=0.
- **Statistics (macro defined).** 3 taken + 2 not-taken retired branches plus 1 stalled branch → `br_cnt`=5, `tk_cnt`=3. Preload to FFFF, then take a branch → both stay FFFF.
- **Statistics (macro undefined).** Same stimulus → `br_cnt`=`tk_cnt`=0, with identical `taken` trace.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC-F23 definitions: branch condition codes, flag bit positions and the flag type.
package wisc_pkg;

  typedef logic [2:0] flags_t;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GTE = 3'b100;
  localparam logic [2:0] COND_LTE = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UN  = 3'b111;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Datapath-side bundle of the flag/branch unit: ALU flags, retirement, branch request and results.
interface flag_branch_unit_if #(
    parameter int unsigned CNT_W = 16
);
    import wisc_pkg::*;

    flags_t           flag_in;
    flags_t           flag_en;
    logic             retire;
    logic             branch;
    logic [2:0]       cond;
    flags_t           flags_q;
    logic             taken;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] tk_cnt;

    modport master (
        output flag_in, flag_en, retire, branch, cond,
        input  flags_q, taken, br_cnt, tk_cnt
    );

    modport slave (
        input  flag_in, flag_en, retire, branch, cond,
        output flags_q, taken, br_cnt, tk_cnt
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 3-bit branch condition against a set of {N,Z,V} flags.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] cond,
    input  flags_t     flags,
    output logic       cond_met
);

    logic n, z, v;

    always_comb begin
        n        = flags[FLAG_N];
        z        = flags[FLAG_Z];
        v        = flags[FLAG_V];
        cond_met = 1'b0;
        unique case (cond)
            COND_NE:  cond_met = ~z;
            COND_EQ:  cond_met = z;
            COND_GT:  cond_met = ~z & ~n;
            COND_LT:  cond_met = n;
            COND_GTE: cond_met = z | (~z & ~n);
            COND_LTE: cond_met = n | z;
            COND_OV:  cond_met = v;
            COND_UN:  cond_met = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register plus branch-taken decision; saturating branch statistics are
// built only when FLAG_BRANCH_STATS_EN is defined.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    flag_branch_unit_if.slave  bus
);

    flags_t flags_q, flags_d;
    logic   cond_met;
    logic   taken;

    branch_cond_eval u_cond (
        .cond     (bus.cond),
        .flags    (flags_q),
        .cond_met (cond_met)
    );

    // Disabled lanes are masked so an undefined flag_in bit can never reach the register.
    always_comb begin
        flags_d = flags_q;
        if (bus.retire) begin
            flags_d = (bus.flag_in & bus.flag_en) | (flags_q & ~bus.flag_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign taken       = bus.branch & bus.retire & cond_met & rst_n;
    assign bus.taken   = taken;
    assign bus.flags_q = flags_q;

`ifdef FLAG_BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, tk_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            if (bus.branch && bus.retire && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (taken && (tk_cnt_q != '1)) begin
                tk_cnt_q <= tk_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.br_cnt = br_cnt_q;
    assign bus.tk_cnt = tk_cnt_q;
`else
    assign bus.br_cnt = '0;
    assign bus.tk_cnt = '0;
`endif

endmodule
